dcache_access_unit: RTL and testbench
=====================================

# dcache_access_unit

Memory-stage access controller between the pipeline's MEM stage and the data cache. Accepts one load or store per handshake, issues a word-aligned read or write with a byte mask to the dcache, and holds the request until `dcache_resp`. It then returns the raw (unaligned) read word together with `funct3` and `mem_sel` to the downstream read-data aligner. One access is in flight at a time, and the pipeline stalls on `req_ready`/`rsp_valid`.

## Interface
Parameters: none.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: MEM stage presents an access.
- `req_read` in 1: access is a load.
- `req_write` in 1: access is a store.
- `req_funct3` in 3: load or store funct3.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data (rs2).
- `req_ready` out 1: high only in IDLE; a request is accepted when `req_valid & req_ready & (req_read | req_write)`.
- `dcache_read` out 1: read strobe, held until response.
- `dcache_write` out 1: write strobe, held until response.
- `dcache_address` out 32: `{addr[31:2], 2'b00}`.
- `dcache_wmask` out 4: byte enables.
- `dcache_wdata` out 32: lane-replicated store data.
- `dcache_rdata` in 32: cache read word.
- `dcache_resp` in 1: cache completion.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_rdata` out 32: captured raw cache word; 0 for stores.
- `rsp_funct3` out 3: funct3 of the completed access.
- `rsp_mem_sel` out 2: `addr[1:0]` of the completed access.
- `rsp_misalign` out 1: misaligned-access flag; present only with `DCACHE_MISALIGN_TRAP_EN`.

## Operation
- **States:**
  - IDLE → READ when an accepted request has `req_read`.
  - IDLE → WRITE when an accepted request has `req_write` and not `req_read`.
  - READ/WRITE → RESP on `dcache_resp`.
  - RESP → IDLE unconditionally.
- **Request decoding:**
  - If `req_read` and `req_write` are both high, the access is treated as a read.
  - `req_valid` with neither strobe is not accepted.
- **Registered on accept:** `addr`, `funct3`, `wdata`, and `wmask`. The dcache outputs are driven from these registers only, never combinationally from `req_*`.
- **Strobes:** `dcache_read` is high exactly in READ and `dcache_write` exactly in WRITE. They are never both high.
- **Store mask and data:**
  - sb: `wmask = 4'b0001 << addr[1:0]`, `wdata = {4{wdata[7:0]}}`.
  - sh: `wmask = (4'b0011 << addr[1:0])` truncated to 4 bits, `wdata = {2{wdata[15:0]}}`.
  - sw: `wmask = 4'b1111`, `wdata` unchanged.
  - funct3 other than sb/sh/sw: `wmask = 4'b0000`; the write is still issued.
- **Read capture:** on `dcache_resp` in READ, `dcache_rdata` is captured into `rsp_rdata`.
- **RESP state:** `rsp_valid` = 1, and `rsp_funct3`/`rsp_mem_sel` hold the registered request.
- **`rsp_*` data outputs:** hold their values until the next response. Only `rsp_valid` pulses.
- **`dcache_resp` outside READ/WRITE:** ignored.

## Timing
- **Reset:** state IDLE; `req_ready` = 1; all other outputs 0.
- **Reset mid-access:** aborts the access immediately. Strobes drop asynchronously, and a later `dcache_resp` is ignored.
- **Latency:**
  - Accept at edge N.
  - Strobe is high from cycle N+1.
  - `dcache_resp` is sampled at edge M ≥ N+1.
  - `rsp_valid` is high in cycle M+1.
  - Minimum accept-to-`rsp_valid` latency is 2 cycles.
- **Throughput:** at most one access per 3 cycles. `req_ready` is low in READ, WRITE and RESP.
- **No timeout:** strobes remain asserted indefinitely until `dcache_resp`.

## Configuration
`DCACHE_MISALIGN_TRAP_EN`:
- **Defined:**
  - An access is misaligned if it is lh/lhu/sh with `addr[0] = 1`, or lw/sw with `addr[1:0] ≠ 0`.
  - A misaligned access is accepted, but IDLE → RESP directly with no dcache strobe.
  - In that RESP cycle `rsp_misalign` = 1 and `rsp_rdata` = 0.
  - `rsp_misalign` is 0 for all other responses.
- **Undefined:**
  - The `rsp_misalign` port is absent.
  - Every access goes to the cache; `mem_sel` is `addr[1:0]` unchanged and masks are truncated as above.

## Structure
- **Shared package `rv32i_types`:**
  - `rv32i_word`, `load_funct3_t`, `store_funct3_t`.
  - New enum `dcache_acc_state_t` {IDLE, READ, WRITE, RESP}.
- **Sub-module `dcache_wdata_aligner`:** combinational; inputs `funct3` and `addr[1:0]`/`wdata`, outputs `wmask` and `wdata`. Mirror of the read-side aligner.

## Test plan
1. lw at 0x1000, resp 3 cycles after strobe, rdata 0xDEADBEEF → `dcache_address` 0x1000; `rsp_rdata` 0xDEADBEEF, `rsp_mem_sel` 0, `rsp_funct3` 010 one cycle after resp.
2. sb at 0x2003, wdata 0x000000A5 → `wmask` 4'b1000, `dcache_wdata` 0xA5A5A5A5, `dcache_address` 0x2000; `rsp_rdata` 0.
3. sh at 0x2002, wdata 0x1234BEEF → `wmask` 4'b1100, `dcache_wdata` 0xBEEFBEEF.
4. Same-cycle resp, then `req_valid` held continuously → `rsp_valid` 2 cycles after accept; next accept no sooner than 3 cycles after the previous one.
5. `rst` pulsed during READ, then stray `dcache_resp` → IDLE, no `rsp_valid`, strobes 0.
6. lw at 0x1002:
   - With `DCACHE_MISALIGN_TRAP_EN`: no strobe, `rsp_misalign` = 1 one cycle after accept.
   - Without it: read of 0x1000, `rsp_mem_sel` = 2.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I types used by the memory-stage blocks.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } dcache_acc_state_t;

endpackage

// File: rtl/dcache_access_unit_wdata_aligner.sv
// Store-side lane steering: byte enables and lane-replicated data for sb/sh/sw.
// Write-side counterpart of the downstream read-data aligner.
module dcache_wdata_aligner
  import rv32i_types::*;
(
  input  logic [2:0] funct3,
  input  logic [1:0] mem_sel,
  input  rv32i_word  store_data,
  output logic [3:0] wmask,
  output rv32i_word  wdata
);

  always_comb begin
    wmask = 4'b0000;
    wdata = store_data;
    case (funct3)
      sb: begin
        wmask = 4'b0001 << mem_sel;
        wdata = {4{store_data[7:0]}};
      end
      sh: begin
        // A halfword at offset 3 keeps only its low byte enable.
        wmask = 4'b0011 << mem_sel;
        wdata = {2{store_data[15:0]}};
      end
      sw: begin
        wmask = 4'b1111;
        wdata = store_data;
      end
      default: begin
        wmask = 4'b0000;
        wdata = store_data;
      end
    endcase
  end

endmodule

// File: rtl/dcache_access_unit.sv
// MEM-stage to dcache access controller: one load/store in flight, raw read word returned.
// Optional DCACHE_MISALIGN_TRAP_EN adds rsp_misalign and skips the cache for misaligned accesses.
module dcache_access_unit
  import rv32i_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_read,
  input  logic       req_write,
  input  logic [2:0] req_funct3,
  input  rv32i_word  req_addr,
  input  rv32i_word  req_wdata,
  output logic       req_ready,
  output logic       dcache_read,
  output logic       dcache_write,
  output rv32i_word  dcache_address,
  output logic [3:0] dcache_wmask,
  output rv32i_word  dcache_wdata,
  input  rv32i_word  dcache_rdata,
  input  logic       dcache_resp,
  output logic       rsp_valid,
  output rv32i_word  rsp_rdata,
  output logic [2:0] rsp_funct3,
  output logic [1:0] rsp_mem_sel
`ifdef DCACHE_MISALIGN_TRAP_EN
  ,
  output logic       rsp_misalign
`endif
);

  dcache_acc_state_t state_reg, state_next;

  rv32i_word  addr_reg;
  logic [2:0] funct3_reg;
  rv32i_word  wdata_reg;
  logic [3:0] wmask_reg;

  rv32i_word  rsp_rdata_reg;
  logic [2:0] rsp_funct3_reg;
  logic [1:0] rsp_mem_sel_reg;

  logic       accept;
  logic       misaligned;
  logic       cache_done;
  logic [3:0] aligned_wmask;
  rv32i_word  aligned_wdata;

  dcache_wdata_aligner u_wdata_aligner (
    .funct3     (req_funct3),
    .mem_sel    (req_addr[1:0]),
    .store_data (req_wdata),
    .wmask      (aligned_wmask),
    .wdata      (aligned_wdata)
  );

  assign accept     = req_valid & req_ready & (req_read | req_write);
  assign cache_done = ((state_reg == READ) || (state_reg == WRITE)) && dcache_resp;

`ifdef DCACHE_MISALIGN_TRAP_EN
  logic rsp_misalign_reg;

  always_comb begin
    misaligned = 1'b0;
    if (req_read) begin
      case (req_funct3)
        lh, lhu: misaligned = req_addr[0];
        lw:      misaligned = |req_addr[1:0];
        default: misaligned = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        sh:      misaligned = req_addr[0];
        sw:      misaligned = |req_addr[1:0];
        default: misaligned = 1'b0;
      endcase
    end
  end

  assign rsp_misalign = rsp_misalign_reg;
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    state_next   = state_reg;
    req_ready    = 1'b0;
    dcache_read  = 1'b0;
    dcache_write = 1'b0;
    rsp_valid    = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          if (misaligned)    state_next = RESP;
          else if (req_read) state_next = READ;
          else               state_next = WRITE;
        end
      end
      READ: begin
        dcache_read = 1'b1;
        if (dcache_resp) state_next = RESP;
      end
      WRITE: begin
        dcache_write = 1'b1;
        if (dcache_resp) state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      funct3_reg      <= '0;
      wdata_reg       <= '0;
      wmask_reg       <= '0;
      rsp_rdata_reg   <= '0;
      rsp_funct3_reg  <= '0;
      rsp_mem_sel_reg <= '0;
`ifdef DCACHE_MISALIGN_TRAP_EN
      rsp_misalign_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg   <= req_addr;
        funct3_reg <= req_funct3;
        wdata_reg  <= aligned_wdata;
        wmask_reg  <= aligned_wmask;
      end
      // Response fields only change when a new response is produced.
      if (cache_done) begin
        rsp_rdata_reg   <= (state_reg == READ) ? dcache_rdata : '0;
        rsp_funct3_reg  <= funct3_reg;
        rsp_mem_sel_reg <= addr_reg[1:0];
`ifdef DCACHE_MISALIGN_TRAP_EN
        rsp_misalign_reg <= 1'b0;
`endif
      end
`ifdef DCACHE_MISALIGN_TRAP_EN
      if (accept && misaligned) begin
        rsp_rdata_reg    <= '0;
        rsp_funct3_reg   <= req_funct3;
        rsp_mem_sel_reg  <= req_addr[1:0];
        rsp_misalign_reg <= 1'b1;
      end
`endif
    end
  end

  assign dcache_address = {addr_reg[31:2], 2'b00};
  assign dcache_wmask   = wmask_reg;
  assign dcache_wdata   = wdata_reg;
  assign rsp_rdata      = rsp_rdata_reg;
  assign rsp_funct3     = rsp_funct3_reg;
  assign rsp_mem_sel    = rsp_mem_sel_reg;

endmodule

// File: tb/tb_dcache_access_unit.sv
// Self-checking bench for dcache_access_unit: scoreboard of expected responses plus per-scenario checks.
// Build with +define+DCACHE_MISALIGN_TRAP_EN to exercise the misalignment trap variant.
module tb_dcache_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_read, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready;
  logic        dcache_read, dcache_write;
  logic [31:0] dcache_address;
  logic [3:0]  dcache_wmask;
  logic [31:0] dcache_wdata;
  logic [31:0] dcache_rdata;
  logic        dcache_resp;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_funct3;
  logic [1:0]  rsp_mem_sel;
`ifdef DCACHE_MISALIGN_TRAP_EN
  logic        rsp_misalign;
`endif

  dcache_access_unit dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_read       (req_read),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_ready      (req_ready),
    .dcache_read    (dcache_read),
    .dcache_write   (dcache_write),
    .dcache_address (dcache_address),
    .dcache_wmask   (dcache_wmask),
    .dcache_wdata   (dcache_wdata),
    .dcache_rdata   (dcache_rdata),
    .dcache_resp    (dcache_resp),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_funct3     (rsp_funct3),
    .rsp_mem_sel    (rsp_mem_sel)
`ifdef DCACHE_MISALIGN_TRAP_EN
    ,
    .rsp_misalign   (rsp_misalign)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  f3;
    logic [1:0]  sel;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  // Scoreboard: every rsp_valid pulse pops and compares one expected response.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && rsp_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid with rdata %h, none expected", rsp_rdata);
      end else begin
        e = sb_q.pop_front();
        checks++;
        if ({rsp_rdata, rsp_funct3, rsp_mem_sel} !== {e.rdata, e.f3, e.sel}) begin
          errors++;
          $display("FAIL rsp_fields: got rdata %h f3 %b sel %0d, want rdata %h f3 %b sel %0d",
                   rsp_rdata, rsp_funct3, rsp_mem_sel, e.rdata, e.f3, e.sel);
        end
`ifdef DCACHE_MISALIGN_TRAP_EN
        checks++;
        if (rsp_misalign !== e.mis) begin
          errors++;
          $display("FAIL rsp_misalign: got %b want %b", rsp_misalign, e.mis);
        end
`endif
      end
      $display("rsp rdata=%h f3=%b sel=%0d", rsp_rdata, rsp_funct3, rsp_mem_sel);
    end
  end

  task automatic start_req(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, input exp_t e,
                           output logic ok);
    logic acc;
    ok = 1'b0;
    req_valid = 1'b1; req_read = rd; req_write = wr;
    req_funct3 = f3; req_addr = a; req_wdata = wd;
    for (int i = 0; i < 10; i++) begin
      acc = req_ready;
      @(posedge clk); #1;
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    if (ok) sb_q.push_back(e);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: got no accept for addr %h, want accept within 10 cycles", a);
    end
    $display("req rd=%b wr=%b f3=%b addr=%h wdata=%h", rd, wr, f3, a, wd);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, dcache_read, dcache_write, rsp_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_ctrl: got ready/rd/wr/vld %b, want 1000",
               {req_ready, dcache_read, dcache_write, rsp_valid});
    end
    checks++;
    if ({dcache_address, dcache_wmask, dcache_wdata} !== 68'd0) begin
      errors++;
      $display("FAIL reset_dcache: got addr %h mask %b wdata %h, want zeros",
               dcache_address, dcache_wmask, dcache_wdata);
    end
    checks++;
    if ({rsp_rdata, rsp_funct3, rsp_mem_sel} !== 37'd0) begin
      errors++;
      $display("FAIL reset_rsp: got rdata %h f3 %b sel %0d, want zeros", rsp_rdata, rsp_funct3, rsp_mem_sel);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load();
    logic [2:0]  f3s[3]   = '{3'b010, 3'b000, 3'b101};
    logic [31:0] addrs[3] = '{32'h0000_1000, 32'h0000_3001, 32'h0000_3006};
    logic [31:0] rds[3]   = '{32'hDEAD_BEEF, 32'h1122_3344, 32'hCAFE_F00D};
    int          dly[3]   = '{2, 0, 1};
    logic ok;
    for (int k = 0; k < 3; k++) begin
      start_req(1'b1, 1'b0, f3s[k], addrs[k], $urandom,
                exp_t'{rds[k], f3s[k], addrs[k][1:0], 1'b0}, ok);
      checks++;
      if ({dcache_read, dcache_write} !== 2'b10 || dcache_address !== {addrs[k][31:2], 2'b00}) begin
        errors++;
        $display("FAIL load_issue: got rd/wr %b addr %h, want 10 addr %h",
                 {dcache_read, dcache_write}, dcache_address, {addrs[k][31:2], 2'b00});
      end
      for (int d = 0; d < dly[k]; d++) begin
        @(posedge clk); #1;
        checks++;
        if ({dcache_read, rsp_valid, req_ready} !== 3'b100) begin
          errors++;
          $display("FAIL load_hold: got rd/vld/ready %b, want 100", {dcache_read, rsp_valid, req_ready});
        end
      end
      dcache_resp = 1'b1; dcache_rdata = rds[k];
      @(posedge clk); #1;
      dcache_resp = 1'b0; dcache_rdata = $urandom;
      checks++;
      if ({rsp_valid, dcache_read, req_ready} !== 3'b100) begin
        errors++;
        $display("FAIL load_resp: got vld/rd/ready %b, want 100", {rsp_valid, dcache_read, req_ready});
      end
      @(posedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_rdata !== rds[k]) begin
        errors++;
        $display("FAIL load_after: got vld %b ready %b rdata %h, want 0 1 %h",
                 rsp_valid, req_ready, rsp_rdata, rds[k]);
      end
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3s[5]   = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b000};
    logic [31:0] addrs[5] = '{32'h0000_2003, 32'h0000_2002, 32'h0000_2004, 32'h0000_2001, 32'h0000_2000};
    logic [31:0] wds[5]   = '{32'h0000_00A5, 32'h1234_BEEF, 32'h89AB_CDEF, 32'h1234_5678, 32'hFFFF_FF7F};
    logic [3:0]  masks[5] = '{4'b1000, 4'b1100, 4'b1111, 4'b0000, 4'b0001};
    logic [31:0] lanes[5] = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'h89AB_CDEF, 32'h0, 32'h7F7F_7F7F};
    logic ok;
    for (int k = 0; k < 5; k++) begin
      start_req(1'b0, 1'b1, f3s[k], addrs[k], wds[k],
                exp_t'{32'h0, f3s[k], addrs[k][1:0], 1'b0}, ok);
      checks++;
      if ({dcache_read, dcache_write} !== 2'b01 || dcache_address !== {addrs[k][31:2], 2'b00}) begin
        errors++;
        $display("FAIL store_issue: got rd/wr %b addr %h, want 01 addr %h",
                 {dcache_read, dcache_write}, dcache_address, {addrs[k][31:2], 2'b00});
      end
      checks++;
      if (dcache_wmask !== masks[k]) begin
        errors++;
        $display("FAIL store_mask: got %b want %b (f3 %b addr %h)", dcache_wmask, masks[k], f3s[k], addrs[k]);
      end
      if (masks[k] != 4'b0000) begin
        checks++;
        if (dcache_wdata !== lanes[k]) begin
          errors++;
          $display("FAIL store_wdata: got %h want %h", dcache_wdata, lanes[k]);
        end
      end
      dcache_resp = 1'b1; dcache_rdata = $urandom;
      @(posedge clk); #1;
      dcache_resp = 1'b0;
      checks++;
      if ({rsp_valid, dcache_write} !== 2'b10) begin
        errors++;
        $display("FAIL store_resp: got vld/wr %b, want 10", {rsp_valid, dcache_write});
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_decode();
    logic ok;
    start_req(1'b1, 1'b1, 3'b010, 32'h0000_5000, 32'h5555_5555,
              exp_t'{32'h0F0F_0F0F, 3'b010, 2'd0, 1'b0}, ok);
    checks++;
    if ({dcache_read, dcache_write} !== 2'b10) begin
      errors++;
      $display("FAIL both_strobes: got rd/wr %b, want 10", {dcache_read, dcache_write});
    end
    dcache_resp = 1'b1; dcache_rdata = 32'h0F0F_0F0F;
    @(posedge clk); #1;
    dcache_resp = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({req_ready, dcache_read, dcache_write, rsp_valid} !== 4'b1000) begin
        errors++;
        $display("FAIL no_strobe_req: got ready/rd/wr/vld %b, want 1000",
                 {req_ready, dcache_read, dcache_write, rsp_valid});
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int acc_cyc[$];
    int rsp_cyc[$];
    int n_acc = 0;
    logic acc;
    logic [31:0] rd;
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
    req_funct3 = 3'b010; req_addr = 32'h0000_6000;
    dcache_resp = 1'b1;
    for (int c = 0; c < 20; c++) begin
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      if (acc) begin
        acc_cyc.push_back(c);
        n_acc++;
        rd = 32'h1000_0000 + n_acc;
        dcache_rdata = rd;
        sb_q.push_back(exp_t'{rd, 3'b010, 2'd0, 1'b0});
        $display("req b2b #%0d addr=%h", n_acc, req_addr);
        req_addr = 32'h0000_6000 + 32'(4 * n_acc);
        if (n_acc == 3) req_valid = 1'b0;
      end
      if (rsp_valid) rsp_cyc.push_back(c);
    end
    dcache_resp = 1'b0; req_read = 1'b0;
    checks++;
    if (acc_cyc.size() != 3 || rsp_cyc.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d accepts %0d responses, want 3 and 3", acc_cyc.size(), rsp_cyc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (rsp_cyc[i] - acc_cyc[i] + 1 != 2) begin
          errors++;
          $display("FAIL b2b_latency: got %0d cycles want 2", rsp_cyc[i] - acc_cyc[i] + 1);
        end
        if (i > 0) begin
          checks++;
          if (acc_cyc[i] - acc_cyc[i-1] != 3) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles want 3", acc_cyc[i] - acc_cyc[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic ok;
    start_req(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'h0,
              exp_t'{32'h0, 3'b010, 2'd0, 1'b0}, ok);
    #3;
    rst = 1'b1;
    sb_q.delete();
    #1;
    checks++;
    if ({dcache_read, dcache_write, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL async_abort: got rd/wr/ready %b, want 001", {dcache_read, dcache_write, req_ready});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    dcache_resp = 1'b1; dcache_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    dcache_resp = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if ({rsp_valid, dcache_read, dcache_write, req_ready} !== 4'b0001 || rsp_rdata !== 32'h0) begin
        errors++;
        $display("FAIL stray_resp: got vld/rd/wr/ready %b rdata %h, want 0001 rdata 0",
                 {rsp_valid, dcache_read, dcache_write, req_ready}, rsp_rdata);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_misalign();
    logic ok;
`ifdef DCACHE_MISALIGN_TRAP_EN
    start_req(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0,
              exp_t'{32'h0, 3'b010, 2'd2, 1'b1}, ok);
    checks++;
    if ({dcache_read, dcache_write, rsp_valid, rsp_misalign} !== 4'b0011) begin
      errors++;
      $display("FAIL misalign_lw: got rd/wr/vld/mis %b, want 0011",
               {dcache_read, dcache_write, rsp_valid, rsp_misalign});
    end
    @(posedge clk); #1;
    start_req(1'b0, 1'b1, 3'b001, 32'h0000_2001, 32'h1234_5678,
              exp_t'{32'h0, 3'b001, 2'd1, 1'b1}, ok);
    checks++;
    if ({dcache_read, dcache_write, rsp_valid, rsp_misalign} !== 4'b0011) begin
      errors++;
      $display("FAIL misalign_sh: got rd/wr/vld/mis %b, want 0011",
               {dcache_read, dcache_write, rsp_valid, rsp_misalign});
    end
    @(posedge clk); #1;
`else
    start_req(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0,
              exp_t'{32'h1357_2468, 3'b010, 2'd2, 1'b0}, ok);
    checks++;
    if (dcache_read !== 1'b1 || dcache_address !== 32'h0000_1000) begin
      errors++;
      $display("FAIL unaligned_lw: got rd %b addr %h, want 1 addr 00001000", dcache_read, dcache_address);
    end
    dcache_resp = 1'b1; dcache_rdata = 32'h1357_2468;
    @(posedge clk); #1;
    dcache_resp = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL unaligned_resp: got vld %b want 1", rsp_valid);
    end
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
    req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
    dcache_rdata = 32'h0; dcache_resp = 1'b0;
    test_reset();
    test_load();
    test_store();
    test_decode();
    test_back_to_back();
    test_reset_mid();
    test_misalign();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending responses, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
